// File: rtl/nested_loop_counter_pkg.sv
// Shared constants and FSM encoding for the nested loop counter.
package nested_loop_counter_pkg;
  localparam int MAX_LEVELS = 8;
  localparam int IDX_W      = 3;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;
endpackage

// File: rtl/nested_loop_counter_level.sv
// One loop level: bound register, wrapping counter and terminal-count flag.
module loop_level #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             bound_we_i,
  input  logic [WIDTH-1:0] bound_din_i,
  input  logic             clear_i,
  input  logic             step_i,
  output logic [WIDTH-1:0] cnt_o,
  output logic             term_o
);
  logic [WIDTH-1:0] bound_q;
  logic [WIDTH-1:0] cnt_q;
  logic [WIDTH-1:0] cnt_d;
  logic [WIDTH-1:0] eff_bound;
  logic             term;

  // A bound of zero behaves as a single-iteration level.
  assign eff_bound = (bound_q == '0) ? WIDTH'(1) : bound_q;
  assign term      = (cnt_q == eff_bound - WIDTH'(1));

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (step_i) begin
      cnt_d = term ? '0 : cnt_q + WIDTH'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bound_q <= WIDTH'(1);
      cnt_q   <= '0;
    end else begin
      cnt_q <= cnt_d;
      if (bound_we_i) begin
        bound_q <= bound_din_i;
      end
    end
  end

  assign cnt_o  = cnt_q;
  assign term_o = term;
endmodule

// File: rtl/nested_loop_counter.sv
// Nested loop counter: LEVELS cascaded loop_level counters, level 0 innermost,
// stepped by en in RUN; co marks the final step and done follows one cycle later.
module nested_loop_counter
  import nested_loop_counter_pkg::*;
#(
  parameter int LEVELS = 3,
  parameter int WIDTH  = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic                    en,
  input  logic                    clr,
  input  logic                    bound_we,
  input  logic [IDX_W-1:0]        bound_idx,
  input  logic [WIDTH-1:0]        bound_din,
  output logic [LEVELS*WIDTH-1:0] cnt,
  output logic [LEVELS-1:0]       last,
  output logic                    busy,
  output logic                    co,
  output logic                    done
);
  state_e            state_q;
  logic              done_q;
  logic              run;
  logic              bound_wr;
  logic              clear;
  logic [LEVELS-1:0] term;
  logic [LEVELS:0]   inner_all;

  assign run      = (state_q == ST_RUN);
  assign bound_wr = bound_we & ~clr & ~run;
  assign clear    = clr | (~run & start);

  // inner_all[i]: every level below i sits at its terminal count.
  assign inner_all[0] = 1'b1;

  for (genvar i = 0; i < LEVELS; i++) begin : g_level
    assign inner_all[i+1] = inner_all[i] & term[i];

    loop_level #(.WIDTH(WIDTH)) u_level (
      .clk         (clk),
      .rst         (rst),
      .bound_we_i  (bound_wr & (bound_idx == IDX_W'(i))),
      .bound_din_i (bound_din),
      .clear_i     (clear),
      .step_i      (run & en & ~clr & inner_all[i]),
      .cnt_o       (cnt[i*WIDTH +: WIDTH]),
      .term_o      (term[i])
    );
  end

  assign last = inner_all[LEVELS:1];
  assign co   = run & en & inner_all[LEVELS];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (start && !clr) begin
            state_q <= ST_RUN;
          end
        end
        ST_RUN: begin
          if (clr) begin
            state_q <= ST_IDLE;
          end else if (co) begin
            state_q <= ST_IDLE;
            done_q  <= 1'b1;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign busy = run;
  assign done = done_q;
endmodule
